// File: rtl/rle_fb_sequencer.sv
// Frame and download sequencer for the RLE framebuffer and its image library.
// Restarts the decompressor on each frame, primes the ROM/decoder pipeline,
// paces decode during active video, and owns the library write port while a
// loader download is in progress.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_FRAME | display blanked, waiting for frame_start
// SYNC       | one-clock decompressor restart pulse
// PRIME      | forced enables filling the ROM/decoder pipeline
// RUN        | enables follow ce_pix & de, display visible
// LOAD       | loader owns the image library write port, display blanked
module rle_fb_sequencer #(
    parameter int PRIME_CYCLES = 2,
    parameter int ADDR_W       = 17
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic              de,
    input  logic              frame_start,
    input  logic [1:0]        req_mode,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              fb_enable,
    output logic              fb_sync,
    output logic [1:0]        fb_mode,
    output logic              fb_wren,
    output logic [ADDR_W-1:0] fb_wraddress,
    output logic [7:0]        fb_data,
    output logic              blank,
    output logic              load_done,
    output logic [ADDR_W:0]   load_bytes
);

    typedef enum logic [2:0] {
        WAIT_FRAME = 3'd0,
        SYNC       = 3'd1,
        PRIME      = 3'd2,
        RUN        = 3'd3,
        LOAD       = 3'd4
    } state_t;

    // Prime length fits in three bits (1..7).
    localparam logic [2:0]      PRIME_LOAD = 3'(PRIME_CYCLES);
    localparam logic [ADDR_W:0] BYTE_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t     state;
    logic [2:0] prime_cnt;

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_FRAME;
            prime_cnt    <= 3'd0;
            fb_enable    <= 1'b0;
            fb_sync      <= 1'b0;
            fb_mode      <= 2'd0;
            fb_wren      <= 1'b0;
            fb_wraddress <= '0;
            fb_data      <= 8'd0;
            blank        <= 1'b1;
            load_done    <= 1'b0;
            load_bytes   <= '0;
        end else begin
            fb_sync   <= 1'b0;
            fb_wren   <= 1'b0;
            load_done <= 1'b0;

            if (dl_active && state != LOAD) begin
                // A download wins over everything, including a same-cycle frame_start.
                state      <= LOAD;
                fb_enable  <= 1'b0;
                blank      <= 1'b1;
                load_bytes <= '0;
                prime_cnt  <= 3'd0;
            end else begin
                case (state)
                    WAIT_FRAME: begin
                        fb_enable <= 1'b0;
                        blank     <= 1'b1;
                        if (frame_start) begin
                            fb_mode <= req_mode;
                            fb_sync <= 1'b1;
                            state   <= SYNC;
                        end
                    end

                    SYNC: begin
                        fb_enable <= 1'b1;
                        prime_cnt <= PRIME_LOAD;
                        state     <= PRIME;
                    end

                    PRIME: begin
                        if (frame_start) begin
                            fb_mode   <= req_mode;
                            fb_sync   <= 1'b1;
                            fb_enable <= 1'b0;
                            state     <= SYNC;
                        end else if (prime_cnt == 3'd1) begin
                            // Pipeline is full: hand pacing to the pixel enable.
                            prime_cnt <= 3'd0;
                            fb_enable <= ce_pix & de;
                            blank     <= 1'b0;
                            state     <= RUN;
                        end else begin
                            prime_cnt <= prime_cnt - 3'd1;
                            fb_enable <= 1'b1;
                        end
                    end

                    RUN: begin
                        if (frame_start) begin
                            // blank is left low so back-to-back frames stay visible.
                            fb_mode   <= req_mode;
                            fb_sync   <= 1'b1;
                            fb_enable <= 1'b0;
                            state     <= SYNC;
                        end else begin
                            fb_enable <= ce_pix & de;
                        end
                    end

                    LOAD: begin
                        if (dl_active) begin
                            if (dl_wr) begin
                                fb_wren      <= 1'b1;
                                fb_wraddress <= dl_addr;
                                fb_data      <= dl_data;
                                if (load_bytes != '1) begin
                                    load_bytes <= load_bytes + BYTE_ONE;
                                end
                            end
                        end else begin
                            // Falling dl_active: any coincident dl_wr is dropped.
                            load_done <= 1'b1;
                            state     <= WAIT_FRAME;
                        end
                    end

                    default: begin
                        fb_enable <= 1'b0;
                        blank     <= 1'b1;
                        state     <= WAIT_FRAME;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rle_fb_sequencer.sv
// Directed bench for rle_fb_sequencer with PRIME_CYCLES=2, ADDR_W=17.
module tb_rle_fb_sequencer;

    logic        clock;
    logic        reset_n;
    logic        ce_pix;
    logic        de;
    logic        frame_start;
    logic [1:0]  req_mode;
    logic        dl_active;
    logic        dl_wr;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
    logic        fb_enable;
    logic        fb_sync;
    logic [1:0]  fb_mode;
    logic        fb_wren;
    logic [16:0] fb_wraddress;
    logic [7:0]  fb_data;
    logic        blank;
    logic        load_done;
    logic [17:0] load_bytes;

    int n_checks = 0;
    int n_fail   = 0;

    rle_fb_sequencer #(.PRIME_CYCLES(2), .ADDR_W(17)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ce_pix       (ce_pix),
        .de           (de),
        .frame_start  (frame_start),
        .req_mode     (req_mode),
        .dl_active    (dl_active),
        .dl_wr        (dl_wr),
        .dl_addr      (dl_addr),
        .dl_data      (dl_data),
        .fb_enable    (fb_enable),
        .fb_sync      (fb_sync),
        .fb_mode      (fb_mode),
        .fb_wren      (fb_wren),
        .fb_wraddress (fb_wraddress),
        .fb_data      (fb_data),
        .blank        (blank),
        .load_done    (load_done),
        .load_bytes   (load_bytes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ce_pix = 1'b0; de = 1'b0; frame_start = 1'b0; req_mode = 2'd0;
        dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = 8'd0;
        step(); step();
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL rst_blank: got %b want 1", blank); end
        n_checks++; if (fb_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b want 0", fb_enable); end
        n_checks++; if (fb_sync !== 1'b0) begin n_fail++; $display("FAIL rst_sync: got %b want 0", fb_sync); end
        n_checks++; if (fb_mode !== 2'd0) begin n_fail++; $display("FAIL rst_mode: got %0d want 0", fb_mode); end
        n_checks++; if (fb_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b want 0", fb_wren); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", load_done); end
        n_checks++; if (load_bytes !== 18'd0) begin n_fail++; $display("FAIL rst_bytes: got %0d want 0", load_bytes); end
        n_checks++; if (fb_wraddress !== 17'd0 || fb_data !== 8'd0) begin n_fail++; $display("FAIL rst_wrbus: got %h/%h want 0/0", fb_wraddress, fb_data); end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (fb_sync !== 1'b0 || blank !== 1'b1 || fb_enable !== 1'b0) begin n_fail++; $display("FAIL idle_wait: got sync=%b blank=%b en=%b want 0/1/0", fb_sync, blank, fb_enable); end
        end
    endtask

    task automatic test_frame_timing();
        logic [1:0] pat [6];
        pat = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11};
        ce_pix = 1'b0; de = 1'b0; req_mode = 2'd3; frame_start = 1'b1;
        step();
        n_checks++; if (fb_sync !== 1'b1 || fb_enable !== 1'b0 || blank !== 1'b1) begin n_fail++; $display("FAIL t1_sync: got sync=%b en=%b blank=%b want 1/0/1", fb_sync, fb_enable, blank); end
        n_checks++; if (fb_mode !== 2'd3) begin n_fail++; $display("FAIL t1_mode: got %0d want 3", fb_mode); end
        frame_start = 1'b0; req_mode = 2'd0;
        step();
        n_checks++; if (fb_sync !== 1'b0 || fb_enable !== 1'b1 || blank !== 1'b1) begin n_fail++; $display("FAIL t2_prime: got sync=%b en=%b blank=%b want 0/1/1", fb_sync, fb_enable, blank); end
        step();
        n_checks++; if (fb_enable !== 1'b1 || blank !== 1'b1) begin n_fail++; $display("FAIL t3_prime: got en=%b blank=%b want 1/1", fb_enable, blank); end
        step();
        n_checks++; if (fb_enable !== 1'b0 || blank !== 1'b0 || fb_sync !== 1'b0) begin n_fail++; $display("FAIL t4_run: got en=%b blank=%b sync=%b want 0/0/0", fb_enable, blank, fb_sync); end
        for (int i = 0; i < 6; i++) begin
            ce_pix = pat[i][1]; de = pat[i][0];
            step();
            n_checks++; if (fb_enable !== (pat[i][1] & pat[i][0]) || blank !== 1'b0) begin n_fail++; $display("FAIL run_enable[%0d]: got en=%b blank=%b want %b/0", i, fb_enable, blank, pat[i][1] & pat[i][0]); end
        end
        ce_pix = 1'b0; de = 1'b0;
    endtask

    task automatic test_mode_latch();
        req_mode = 2'd0; frame_start = 1'b1;
        step();
        n_checks++; if (fb_mode !== 2'd0 || fb_sync !== 1'b1 || blank !== 1'b0) begin n_fail++; $display("FAIL b2b_sync: got mode=%0d sync=%b blank=%b want 0/1/0", fb_mode, fb_sync, blank); end
        frame_start = 1'b0;
        step();
        n_checks++; if (fb_enable !== 1'b1 || blank !== 1'b0) begin n_fail++; $display("FAIL b2b_prime: got en=%b blank=%b want 1/0", fb_enable, blank); end
        step(); step();
        req_mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (fb_mode !== 2'd0) begin n_fail++; $display("FAIL mode_hold[%0d]: got %0d want 0", i, fb_mode); end
        end
        frame_start = 1'b1;
        step();
        n_checks++; if (fb_mode !== 2'd2) begin n_fail++; $display("FAIL mode_latch: got %0d want 2", fb_mode); end
        frame_start = 1'b0; req_mode = 2'd0;
        step(); step(); step();
        n_checks++; if (fb_mode !== 2'd2 || blank !== 1'b0) begin n_fail++; $display("FAIL mode_after: got mode=%0d blank=%b want 2/0", fb_mode, blank); end
    endtask

    task automatic test_restart_in_prime();
        req_mode = 2'd1; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        frame_start = 1'b1;
        step();
        n_checks++; if (fb_sync !== 1'b1 || fb_mode !== 2'd1 || fb_enable !== 1'b0) begin n_fail++; $display("FAIL prime_restart: got sync=%b mode=%0d en=%b want 1/1/0", fb_sync, fb_mode, fb_enable); end
        frame_start = 1'b0;
        step();
        n_checks++; if (fb_enable !== 1'b1 || fb_sync !== 1'b0) begin n_fail++; $display("FAIL restart_p1: got en=%b sync=%b want 1/0", fb_enable, fb_sync); end
        step();
        n_checks++; if (fb_enable !== 1'b1) begin n_fail++; $display("FAIL restart_p2: got en=%b want 1", fb_enable); end
        step();
        n_checks++; if (fb_enable !== 1'b0 || blank !== 1'b0) begin n_fail++; $display("FAIL restart_run: got en=%b blank=%b want 0/0", fb_enable, blank); end
    endtask

    task automatic test_download();
        logic [16:0] ea;
        logic [7:0]  ed;
        ce_pix = 1'b1; de = 1'b1; dl_active = 1'b1;
        step();
        n_checks++; if (fb_enable !== 1'b0 || blank !== 1'b1 || fb_sync !== 1'b0 || fb_wren !== 1'b0) begin n_fail++; $display("FAIL load_entry: got en=%b blank=%b sync=%b wren=%b want 0/1/0/0", fb_enable, blank, fb_sync, fb_wren); end
        for (int i = 0; i < 5; i++) begin
            ea = 17'h1FFFB + 17'(i);
            ed = 8'hA1 + 8'(i);
            dl_wr = 1'b1; dl_addr = ea; dl_data = ed;
            step();
            n_checks++; if (fb_wren !== 1'b1 || fb_wraddress !== ea || fb_data !== ed) begin n_fail++; $display("FAIL load_wr[%0d]: got wren=%b addr=%h data=%h want 1/%h/%h", i, fb_wren, fb_wraddress, fb_data, ea, ed); end
            n_checks++; if (load_bytes !== 18'(i + 1) || fb_enable !== 1'b0) begin n_fail++; $display("FAIL load_cnt[%0d]: got bytes=%0d en=%b want %0d/0", i, load_bytes, fb_enable, i + 1); end
        end
        dl_wr = 1'b0;
        step();
        n_checks++; if (fb_wren !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL load_idle: got wren=%b done=%b want 0/0", fb_wren, load_done); end
        dl_active = 1'b0; dl_wr = 1'b1; dl_addr = 17'h00012; dl_data = 8'hEE;
        step();
        n_checks++; if (load_done !== 1'b1 || fb_wren !== 1'b0 || blank !== 1'b1) begin n_fail++; $display("FAIL load_exit: got done=%b wren=%b blank=%b want 1/0/1", load_done, fb_wren, blank); end
        n_checks++; if (load_bytes !== 18'd5 || fb_wraddress !== 17'h1FFFF || fb_data !== 8'hA5) begin n_fail++; $display("FAIL load_final: got bytes=%0d addr=%h data=%h want 5/1ffff/a5", load_bytes, fb_wraddress, fb_data); end
        dl_wr = 1'b0;
        step();
        n_checks++; if (load_done !== 1'b0 || fb_sync !== 1'b0 || blank !== 1'b1) begin n_fail++; $display("FAIL post_load: got done=%b sync=%b blank=%b want 0/0/1", load_done, fb_sync, blank); end
        frame_start = 1'b1;
        step();
        n_checks++; if (fb_sync !== 1'b1 || blank !== 1'b1) begin n_fail++; $display("FAIL reload_sync: got sync=%b blank=%b want 1/1", fb_sync, blank); end
        frame_start = 1'b0;
        step();
        n_checks++; if (blank !== 1'b1 || fb_enable !== 1'b1) begin n_fail++; $display("FAIL reload_p1: got blank=%b en=%b want 1/1", blank, fb_enable); end
        step();
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL reload_p2: got blank=%b want 1", blank); end
        step();
        n_checks++; if (blank !== 1'b0 || fb_enable !== 1'b1) begin n_fail++; $display("FAIL reload_run: got blank=%b en=%b want 0/1", blank, fb_enable); end
    endtask

    task automatic test_wr_without_active();
        dl_active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dl_wr = 1'b1; dl_addr = 17'(i); dl_data = 8'(8'h30 + i);
            step();
            n_checks++; if (fb_wren !== 1'b0 || load_bytes !== 18'd5 || fb_wraddress !== 17'h1FFFF) begin n_fail++; $display("FAIL stray_wr[%0d]: got wren=%b bytes=%0d addr=%h want 0/5/1ffff", i, fb_wren, load_bytes, fb_wraddress); end
        end
        dl_wr = 1'b0;
    endtask

    task automatic test_dl_priority();
        ce_pix = 1'b1; de = 1'b1;
        step();
        n_checks++; if (fb_enable !== 1'b1) begin n_fail++; $display("FAIL prio_pre: got en=%b want 1", fb_enable); end
        dl_active = 1'b1; frame_start = 1'b1;
        step();
        n_checks++; if (fb_sync !== 1'b0 || fb_enable !== 1'b0 || blank !== 1'b1) begin n_fail++; $display("FAIL prio_entry: got sync=%b en=%b blank=%b want 0/0/1", fb_sync, fb_enable, blank); end
        n_checks++; if (load_bytes !== 18'd0) begin n_fail++; $display("FAIL prio_clear: got bytes=%0d want 0", load_bytes); end
        frame_start = 1'b0;
        step();
        n_checks++; if (fb_sync !== 1'b0 || fb_enable !== 1'b0) begin n_fail++; $display("FAIL prio_load: got sync=%b en=%b want 0/0", fb_sync, fb_enable); end
        dl_active = 1'b0;
        step();
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL prio_done: got %b want 1", load_done); end
        step();
        n_checks++; if (load_done !== 1'b0 || fb_sync !== 1'b0) begin n_fail++; $display("FAIL prio_after: got done=%b sync=%b want 0/0", load_done, fb_sync); end
        ce_pix = 1'b0; de = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        dl_active = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            dl_wr = 1'b1; dl_addr = 17'h00100 + 17'(i); dl_data = 8'h10 + 8'(i);
            step();
            n_checks++; if (fb_wren !== 1'b1 || load_bytes !== 18'(i + 1)) begin n_fail++; $display("FAIL rl_wr[%0d]: got wren=%b bytes=%0d want 1/%0d", i, fb_wren, load_bytes, i + 1); end
        end
        dl_addr = 17'h00102; dl_data = 8'h12;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (fb_wren !== 1'b0 || blank !== 1'b1 || load_bytes !== 18'd0) begin n_fail++; $display("FAIL rl_async: got wren=%b blank=%b bytes=%0d want 0/1/0", fb_wren, blank, load_bytes); end
        n_checks++; if (fb_wraddress !== 17'd0 || fb_data !== 8'd0 || fb_mode !== 2'd0) begin n_fail++; $display("FAIL rl_async_bus: got addr=%h data=%h mode=%0d want 0/0/0", fb_wraddress, fb_data, fb_mode); end
        dl_active = 1'b0; dl_wr = 1'b0;
        step();
        n_checks++; if (fb_wren !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL rl_hold: got wren=%b done=%b want 0/0", fb_wren, load_done); end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (fb_sync !== 1'b0 || blank !== 1'b1) begin n_fail++; $display("FAIL rl_wait[%0d]: got sync=%b blank=%b want 0/1", i, fb_sync, blank); end
        end
        frame_start = 1'b1;
        step();
        n_checks++; if (fb_sync !== 1'b1) begin n_fail++; $display("FAIL rl_sync: got %b want 1", fb_sync); end
        frame_start = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_mode_latch();
        test_restart_in_prime();
        test_download();
        test_wr_without_active();
        test_dl_priority();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
